mds_rc_stage: RTL and testbench
===============================

MDS_RC_STAGE -- requirements
Module: mds_rc_stage

Interface
REQ-001 The module SHALL have parameter WORD_WIDTH, default 31: M31 field word width.
REQ-002 The module SHALL have parameter MTX_SIZE, default 16: number of state lanes.
REQ-003 The module SHALL have parameter LANES, default 4: lanes added per cycle; MTX_SIZE SHALL be a multiple of LANES.
REQ-004 The module SHALL have parameter NUM_ROUNDS, default 14: round count per permutation.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port in_vec, input, MTX_SIZE x WORD_WIDTH: output of the upstream circulant matrix-vector multiplier.
REQ-008 The module SHALL have port in_valid, input, 1 bit: the multiplier result is valid.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the stage can capture.
REQ-010 The module SHALL have port rc, input, MTX_SIZE x WORD_WIDTH: round constants for round_idx, supplied externally.
REQ-011 The module SHALL have port round_idx, output, $clog2(NUM_ROUNDS) bits: current round.
REQ-012 The module SHALL have port round_clr, input, 1 bit: synchronous restart of the round count.
REQ-013 The module SHALL have port out_vec, output, MTX_SIZE x WORD_WIDTH: in_vec + rc, computed mod p = 2^31-1.
REQ-014 The module SHALL have port out_valid, output, 1 bit; and port out_ready, input, 1 bit.

Function
REQ-015 The FSM SHALL have three states: IDLE, ADD and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, in_valid=1 at a clock edge SHALL copy in_vec into an internal buffer, clear the beat counter and move to ADD.
REQ-017 Each ADD cycle SHALL replace buffer lanes [beat*LANES, beat*LANES+LANES-1] with mod-p sums against the matching rc lanes, then increment beat.
REQ-018 After the last beat (MTX_SIZE/LANES-1), the FSM SHALL move to DONE; out_valid SHALL rise MTX_SIZE/LANES edges after the capture edge (4 by default).
REQ-019 Mod-p add SHALL be: s = a + b at 32 bits; r = s[30:0] + s[31]; result r lies in [0, p].
REQ-020 In DONE, out_valid SHALL be 1 and out_vec SHALL equal the buffer; out_vec SHALL stay stable until out_ready=1.
REQ-021 out_valid=1 and out_ready=1 at an edge SHALL return the FSM to IDLE and increment round_idx; round_idx SHALL wrap from NUM_ROUNDS-1 to 0.
REQ-022 rc SHALL be sampled during ADD only; rc SHALL be held constant for round_idx from capture until DONE.
REQ-023 round_clr=1 SHALL zero round_idx at the next edge and SHALL override an increment in the same cycle; round_clr SHALL NOT alter FSM state or the buffer.
REQ-024 in_valid SHALL be ignored outside IDLE; no capture SHALL occur in the cycle of DONE->IDLE.

Reset
REQ-025 reset=0 SHALL force, asynchronously: state=IDLE, in_ready=1, out_valid=0, round_idx=0, beat=0, buffer=0, out_vec=0.
REQ-026 Reset asserted mid-ADD or in DONE SHALL abandon the vector with no output produced.

Configuration
REQ-027 With MDS_RC_CANON_EN defined, every ADD result equal to p (0x7FFFFFFF) SHALL be stored as 0, so out_vec is canonical in [0, p-1].
REQ-028 Without MDS_RC_CANON_EN, results SHALL be stored as computed in REQ-019, and value p SHALL be allowed in out_vec.

Structure
REQ-029 A shared package SHALL hold: M31_P, the word typedef m31_t, the state-vector typedef, and the enum of FSM states.
REQ-030 The lane add SHALL be one sub-module, m31_mod_add, instanced LANES times; the MDS_RC_CANON_EN option SHALL live inside it.

Verification
REQ-031 Bench: in_vec[i]=i, rc[i]=100; capture -> out_valid at capture+4 edges; out_vec[i]=100+i; round_idx goes 0->1 on accept.
REQ-032 Bench: lane 0 = 0x7FFFFFFE, rc[0]=5 -> out_vec[0]=4. Lane 1 = 0x7FFFFFFE, rc[1]=1 -> 0x7FFFFFFF without the macro, 0 with MDS_RC_CANON_EN.
REQ-033 Bench: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, out_vec stable, in_ready=0, new in_valid ignored.
REQ-034 Bench: 14 accepted vectors -> round_idx runs 0..13 then 0. round_clr pulsed at the same edge as an accept -> round_idx=0.
REQ-035 Bench: reset=0 two cycles after capture -> out_valid=0, in_ready=1 immediately; no out_valid follows; round_idx=0.

Source files
------------

// File: rtl/mds_rc_stage_pkg.sv
// Shared types for the MDS round-constant stage: M31 modulus, word and
// state-vector types, and the stage FSM encoding.
package mds_rc_stage_pkg;

    localparam int unsigned M31_W    = 31;
    localparam int unsigned MDS_SIZE = 16;

    // Mersenne-31 prime, p = 2^31 - 1
    localparam logic [M31_W-1:0] M31_P = 31'h7FFF_FFFF;

    typedef logic [M31_W-1:0]      m31_t;
    typedef m31_t [MDS_SIZE-1:0]   m31_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mds_rc_stage_if.sv
// Bus between the circulant multiplier, the round-constant source and the
// consumer of the MDS round-constant stage.
interface mds_rc_stage_if #(
    parameter int unsigned WORD_WIDTH = 31,
    parameter int unsigned MTX_SIZE   = 16,
    parameter int unsigned NUM_ROUNDS = 14
);
    localparam int unsigned RIW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] in_vec;
    logic                                in_valid;
    logic                                in_ready;
    logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] rc;
    logic [RIW-1:0]                      round_idx;
    logic                                round_clr;
    logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] out_vec;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        output in_vec, in_valid, rc, round_clr, out_ready,
        input  in_ready, round_idx, out_vec, out_valid
    );

    modport slave (
        input  in_vec, in_valid, rc, round_clr, out_ready,
        output in_ready, round_idx, out_vec, out_valid
    );

endinterface

// File: rtl/m31_mod_add.sv
// Single-lane addition modulo 2^WORD_WIDTH - 1 (Mersenne reduction by
// end-around carry). Optional macro MDS_RC_CANON_EN folds a result equal
// to p onto 0 so the output is canonical.
module m31_mod_add #(
    parameter int unsigned WORD_WIDTH = 31
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic [WORD_WIDTH-1:0] sum
);

    // All-ones word is the modulus p for a Mersenne prime
    localparam logic [WORD_WIDTH-1:0] P_VAL = '1;

    logic [WORD_WIDTH:0]   s;
    logic [WORD_WIDTH-1:0] r;

    // Wide add, then fold the carry back in; r can equal p but never exceeds it
    always_comb begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WORD_WIDTH-1:0] + {{(WORD_WIDTH-1){1'b0}}, s[WORD_WIDTH]};
`ifdef MDS_RC_CANON_EN
        sum = (r == P_VAL) ? '0 : r;
`else
        sum = r;
`endif
    end

endmodule

// File: rtl/mds_rc_stage.sv
// MDS round-constant stage: captures the multiplier output, adds the
// per-round constants LANES lanes per cycle mod p, then holds the result
// until the consumer accepts it and advances the round counter.
// Optional macro MDS_RC_CANON_EN (inside m31_mod_add) makes out_vec canonical.
module mds_rc_stage
    import mds_rc_stage_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 31,
    parameter int unsigned MTX_SIZE   = 16,
    parameter int unsigned LANES      = 4,
    parameter int unsigned NUM_ROUNDS = 14
) (
    input  logic           clk,
    input  logic           reset,
    mds_rc_stage_if.slave  bus
);

    localparam int unsigned BEATS = MTX_SIZE / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned RIW   = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    localparam logic [BW-1:0]  BEAT_LAST  = BW'(BEATS - 1);
    localparam logic [RIW-1:0] ROUND_LAST = RIW'(NUM_ROUNDS - 1);

    // Buffer and constants are viewed as [beat][lane] so the active beat is a
    // plain index; the packed layout matches the flat lane order of the bus.
    typedef logic [BEATS-1:0][LANES-1:0][WORD_WIDTH-1:0] beat_vec_t;

    state_e                            state_q, state_d;
    logic [BW-1:0]                     beat_q, beat_d;
    logic [RIW-1:0]                    round_q, round_d;
    beat_vec_t                         buf_q, buf_d;
    logic                              in_ready_q, in_ready_d;
    logic                              out_valid_q, out_valid_d;

    beat_vec_t                         rc_beats;
    logic [LANES-1:0][WORD_WIDTH-1:0]  lane_a;
    logic [LANES-1:0][WORD_WIDTH-1:0]  lane_b;
    logic [LANES-1:0][WORD_WIDTH-1:0]  lane_sum;

    assign rc_beats = bus.rc;
    assign lane_a   = buf_q[beat_q];
    assign lane_b   = rc_beats[beat_q];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        m31_mod_add #(
            .WORD_WIDTH (WORD_WIDTH)
        ) u_add (
            .a   (lane_a[g]),
            .b   (lane_b[g]),
            .sum (lane_sum[g])
        );
    end

    // Next-state, buffer update and round counter
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        round_d = round_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_d   = bus.in_vec;
                    beat_d  = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                buf_d[beat_q] = lane_sum;
                beat_d        = beat_q + 1'b1;
                if (beat_q == BEAT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    round_d = (round_q == ROUND_LAST) ? '0 : round_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Restart wins over an accept in the same cycle
        if (bus.round_clr) begin
            round_d = '0;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            round_q     <= '0;
            buf_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            round_q     <= round_d;
            buf_q       <= buf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = buf_q;
    assign bus.round_idx = round_q;

endmodule

// File: tb/tb_mds_rc_stage.sv
// Self-checking bench for mds_rc_stage: directed corner vectors plus random
// vectors checked against a plain-arithmetic mod-p reference.
module tb_mds_rc_stage;

    localparam int unsigned W      = 31;
    localparam int unsigned N      = 16;
    localparam int unsigned L      = 4;
    localparam int unsigned ROUNDS = 14;
    localparam longint unsigned P  = 64'h7FFF_FFFF;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic clk;
    logic reset;

    mds_rc_stage_if #(
        .WORD_WIDTH (W),
        .MTX_SIZE   (N),
        .NUM_ROUNDS (ROUNDS)
    ) bus ();

    mds_rc_stage #(
        .WORD_WIDTH (W),
        .MTX_SIZE   (N),
        .LANES      (L),
        .NUM_ROUNDS (ROUNDS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_round = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: ordinary integer addition reduced into [0, p]
    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned t;
        t = longint'(a) + longint'(b);
        if (t > P) t = t - P;
`ifdef MDS_RC_CANON_EN
        if (t == P) t = 0;
`endif
        return t[W-1:0];
    endfunction

    function automatic vec_t ref_vec(input vec_t v, input vec_t r);
        vec_t o;
        for (int i = 0; i < int'(N); i++) o[i] = ref_add(v[i], r[i]);
        return o;
    endfunction

    function automatic vec_t rand_vec();
        vec_t o;
        for (int i = 0; i < int'(N); i++) o[i] = W'($urandom & 32'h7FFF_FFFF);
        return o;
    endfunction

    // Present a vector, wait for the result and compare it against the model
    task automatic run_vector(input string tag, input vec_t v, input vec_t r);
        int   lat;
        vec_t exp_v;
        exp_v = ref_vec(v, r);
        bus.in_vec   = v;
        bus.rc       = r;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_vec   = rand_vec();
        check({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("%s_lane%0d", tag, i), 64'(bus.out_vec[i]), 64'(exp_v[i]));
        end
    endtask

    task automatic accept(input string tag, input logic clr);
        bus.out_ready = 1'b1;
        bus.round_clr = clr;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.round_clr = 1'b0;
        exp_round = clr ? 0 : (exp_round + 1) % int'(ROUNDS);
        check({tag, "_round_idx"}, 64'(bus.round_idx), 64'(exp_round));
        check({tag, "_out_valid_low"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready_high"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, r, hold_exp;

        reset         = 1'b0;
        bus.in_vec    = '0;
        bus.in_valid  = 1'b0;
        bus.rc        = '0;
        bus.round_clr = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_round_idx", 64'(bus.round_idx), 64'd0);
        check("rst_out_vec", 64'(bus.out_vec == '0), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Ramp input plus constant 100
        for (int i = 0; i < int'(N); i++) begin
            v[i] = W'(i);
            r[i] = W'(100);
        end
        run_vector("basic", v, r);
        check("basic_lane5_literal", 64'(bus.out_vec[5]), 64'd105);
        accept("basic", 1'b0);

        // Wrap-around and the value-p corner
        v = rand_vec();
        r = rand_vec();
        v[0] = 31'h7FFF_FFFE; r[0] = 31'd5;
        v[1] = 31'h7FFF_FFFE; r[1] = 31'd1;
        run_vector("edge", v, r);
        check("edge_lane0_literal", 64'(bus.out_vec[0]), 64'd4);
`ifdef MDS_RC_CANON_EN
        check("edge_lane1_literal", 64'(bus.out_vec[1]), 64'd0);
`else
        check("edge_lane1_literal", 64'(bus.out_vec[1]), 64'h7FFF_FFFF);
`endif
        accept("edge", 1'b0);

        // Back-pressure in DONE with a competing in_valid
        v = rand_vec();
        r = rand_vec();
        hold_exp = ref_vec(v, r);
        run_vector("hold", v, r);
        bus.rc       = rand_vec();
        bus.in_vec   = rand_vec();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_out_vec", 64'(bus.out_vec == hold_exp), 64'd1);
        end
        accept("hold", 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("hold_no_capture", 64'(bus.in_ready), 64'd1);

        // Restart alone leaves the FSM idle
        bus.round_clr = 1'b1;
        @(posedge clk); #1;
        bus.round_clr = 1'b0;
        exp_round = 0;
        check("clr_round_idx", 64'(bus.round_idx), 64'd0);
        check("clr_in_ready", 64'(bus.in_ready), 64'd1);

        // Full round sweep with random data: 1..13 then back to 0
        for (int k = 0; k < int'(ROUNDS); k++) begin
            run_vector($sformatf("rnd%0d", k), rand_vec(), rand_vec());
            accept($sformatf("rnd%0d", k), 1'b0);
        end
        check("sweep_wrapped", 64'(bus.round_idx), 64'd0);

        // Restart in the same edge as an accept
        run_vector("clracc_pre", rand_vec(), rand_vec());
        accept("clracc_pre", 1'b0);
        run_vector("clracc", rand_vec(), rand_vec());
        accept("clracc", 1'b1);
        run_vector("prerst", rand_vec(), rand_vec());
        accept("prerst", 1'b0);

        // Reset two cycles into ADD abandons the vector
        bus.in_vec   = rand_vec();
        bus.rc       = rand_vec();
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_round = 0;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_round_idx", 64'(bus.round_idx), 64'd0);
        check("mid_rst_out_vec", 64'(bus.out_vec == '0), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
        end

        run_vector("after_rst", rand_vec(), rand_vec());
        accept("after_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
